// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: PDM microphone capture sequencer.
//
// Generates mic_clk from clk with a start/stop-gated half-period divider,
// discards WARMUP whole frames after start, then packs DECIM PDM bits per
// frame into a signed PCM sample (2*ones - DECIM). Samples are handed to the
// consumer over a valid/ready register that holds until accepted.
//
// Parameters:
//   FI      system clock frequency (Hz)
//   FS_PDM  mic_clk frequency (Hz); HALF = FI/(2*FS_PDM) must be >= 2
//   DECIM   PDM bits per sample, power of two, 2..1024
//   WARMUP  whole frames discarded after start (>= 1)
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start, stop       one-cycle control pulses
//   mic_clk           PDM clock to the microphone
//   mic_data          PDM data (already synchronised)
//   pcm_data          signed 16-bit sample
//   pcm_valid         sample available, held until pcm_ready
//   pcm_ready         consumer accept
//   busy              high in any state except IDLE
//   overrun           sticky: a completed frame was dropped
//   pcm_chan          (MIC_STEREO_EN only) 0 = left, 1 = right
//
// Optional build macro: MIC_STEREO_EN adds a right channel sampled on the
// mic_clk 0->1 events with its own accumulator and the pcm_chan output.

module mic_capture_ctrl #(
  parameter int unsigned FI     = 50000000,
  parameter int unsigned FS_PDM = 2500000,
  parameter int unsigned DECIM  = 64,
  parameter int unsigned WARMUP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic        mic_clk,
  input  logic        mic_data,
  output logic [15:0] pcm_data,
  output logic        pcm_valid,
  input  logic        pcm_ready,
`ifdef MIC_STEREO_EN
  output logic        pcm_chan,
`endif
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned HALF  = FI / (2 * FS_PDM);
  localparam int unsigned CntW  = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int unsigned BitW  = $clog2(DECIM);
  localparam int unsigned OnesW = BitW + 1;
  localparam int unsigned WarmW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [CntW-1:0]  HalfLast = CntW'(HALF - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DECIM - 1);
  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWarm,
    StRun,
    StFinish
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mic_clk_q, mic_clk_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [OnesW-1:0] ones_q, ones_d;
  logic [WarmW-1:0] warm_q, warm_d;
  logic [15:0]      pcm_q, pcm_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             busy_w;
  logic             tick;
  logic             fall_ev;
  logic             l_done;
  logic [OnesW-1:0] l_ones;
  logic             frame_end;
  logic             take_start;
  logic             emit_l;
  logic             accept;

`ifdef MIC_STEREO_EN
  logic             rise_ev;
  logic             r_done;
  logic [OnesW-1:0] r_ones;
  logic             emit_r;
  logic             r_armed_q, r_armed_d;
  logic [BitW-1:0]  r_bit_q, r_bit_d;
  logic [OnesW-1:0] r_ones_q, r_ones_d;
  logic             chan_q, chan_d;
`endif

  // 2*ones - DECIM in two's complement; the 16-bit wrap gives the sign extension.
  function automatic logic [15:0] to_pcm(input logic [OnesW-1:0] n);
    return (16'(n) << 1) - 16'(DECIM);
  endfunction

  assign busy_w  = (state_q != StIdle);
  assign tick    = busy_w && (cnt_q == '0);
  // Left/mono bit sample: the cycle in which mic_clk is driven 1->0.
  assign fall_ev = tick && mic_clk_q;
  assign l_done  = fall_ev && (bit_q == BitLast);
  // The bit sampled in the completing cycle still belongs to that frame.
  assign l_ones  = ones_q + OnesW'(mic_data);
  assign accept  = valid_q && pcm_ready;

`ifdef MIC_STEREO_EN
  // Right bits come from 0->1 events. The right channel arms on the first
  // left event so that each right frame closes HALF clk after its left frame.
  assign rise_ev   = tick && !mic_clk_q && r_armed_q;
  assign r_done    = rise_ev && (r_bit_q == BitLast);
  assign r_ones    = r_ones_q + OnesW'(mic_data);
  // State transitions follow the later (right) frame of each pair.
  assign frame_end = r_done;
`else
  assign frame_end = l_done;
`endif

  // Control FSM: next state and frame emission decisions.
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    take_start = 1'b0;
    emit_l     = 1'b0;
`ifdef MIC_STEREO_EN
    emit_r     = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        // start wins over a coincident stop.
        if (start) begin
          state_d    = StWarm;
          take_start = 1'b1;
        end
      end
      StWarm: begin
        if (stop) begin
          state_d = StIdle;
        end else if (frame_end) begin
          if (warm_q == WarmLast) begin
            state_d = StRun;
          end else begin
            warm_d = warm_q + WarmW'(1);
          end
        end
      end
      StRun: begin
        emit_l = l_done;
`ifdef MIC_STEREO_EN
        emit_r = r_done;
`endif
        // A frame completing together with stop is emitted here, and
        // FINISH then captures one more full frame.
        if (stop) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        emit_l = l_done;
`ifdef MIC_STEREO_EN
        emit_r = r_done;
`endif
        if (frame_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (take_start) begin
      warm_d = '0;
    end
  end

  // Divider and left/mono frame accumulator.
  always_comb begin
    cnt_d     = cnt_q;
    mic_clk_d = mic_clk_q;
    bit_d     = bit_q;
    ones_d    = ones_q;
    if (busy_w) begin
      if (tick) begin
        cnt_d     = HalfLast;
        mic_clk_d = ~mic_clk_q;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
    if (fall_ev) begin
      if (l_done) begin
        bit_d  = '0;
        ones_d = '0;
      end else begin
        bit_d  = bit_q + BitW'(1);
        ones_d = l_ones;
      end
    end
    if (take_start) begin
      cnt_d     = HalfLast;
      mic_clk_d = 1'b0;
      bit_d     = '0;
      ones_d    = '0;
    end
    // Covers both stop-from-WARM and the end of FINISH.
    if (state_d == StIdle) begin
      mic_clk_d = 1'b0;
    end
  end

`ifdef MIC_STEREO_EN
  // Right channel accumulator.
  always_comb begin
    r_armed_d = r_armed_q;
    r_bit_d   = r_bit_q;
    r_ones_d  = r_ones_q;
    if (fall_ev) begin
      r_armed_d = 1'b1;
    end
    if (rise_ev) begin
      if (r_done) begin
        r_bit_d  = '0;
        r_ones_d = '0;
      end else begin
        r_bit_d  = r_bit_q + BitW'(1);
        r_ones_d = r_ones;
      end
    end
    if (take_start) begin
      r_armed_d = 1'b0;
      r_bit_d   = '0;
      r_ones_d  = '0;
    end
  end
`endif

  // Output register: a held sample blocks new frames, which are then dropped.
  always_comb begin
    valid_d = valid_q;
    pcm_d   = pcm_q;
    ovr_d   = ovr_q;
`ifdef MIC_STEREO_EN
    chan_d  = chan_q;
`endif
    if (accept) begin
      valid_d = 1'b0;
    end
    if (emit_l) begin
      if (!valid_q || pcm_ready) begin
        valid_d = 1'b1;
        pcm_d   = to_pcm(l_ones);
`ifdef MIC_STEREO_EN
        chan_d  = 1'b0;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
`ifdef MIC_STEREO_EN
    if (emit_r) begin
      if (!valid_q || pcm_ready) begin
        valid_d = 1'b1;
        pcm_d   = to_pcm(r_ones);
        chan_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
`endif
    if (take_start) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mic_clk_q <= 1'b0;
      bit_q     <= '0;
      ones_q    <= '0;
      warm_q    <= '0;
      pcm_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mic_clk_q <= mic_clk_d;
      bit_q     <= bit_d;
      ones_q    <= ones_d;
      warm_q    <= warm_d;
      pcm_q     <= pcm_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef MIC_STEREO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed_q <= 1'b0;
      r_bit_q   <= '0;
      r_ones_q  <= '0;
      chan_q    <= 1'b0;
    end else begin
      r_armed_q <= r_armed_d;
      r_bit_q   <= r_bit_d;
      r_ones_q  <= r_ones_d;
      chan_q    <= chan_d;
    end
  end

  assign pcm_chan = chan_q;
`endif

  assign mic_clk   = mic_clk_q;
  assign pcm_data  = pcm_q;
  assign pcm_valid = valid_q;
  assign busy      = busy_w;
  assign overrun   = ovr_q;

endmodule

// File: doc/mic_capture_ctrl.md
Name: mic_capture_ctrl

Overview:
- Sequences PDM microphone capture: generates mic_clk from clk through an internal gated divider, discards a warm-up interval, then packs DECIM PDM bits per frame into signed PCM samples.
- Presents samples on a valid/ready interface to the downstream PCM/audio path.
- Sits between the microphone pins and the PCM sample consumer; replaces the free-running mic clock divider with a start/stop-controlled one.

Parameters:
- FI, 50000000, system clock frequency in Hz.
- FS_PDM, 2500000, mic_clk frequency in Hz. HALF = FI/(2*FS_PDM) must be >= 2 (default 10).
- DECIM, 64, PDM bits per PCM sample. Power of two, 2..1024.
- WARMUP, 16, number of whole frames discarded after start.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins capture. Ignored unless IDLE.
- stop  in  1  one-cycle pulse; ends capture. Ignored in IDLE and FINISH.
- mic_clk  out  1  PDM clock to the microphone.
- mic_data  in  1  PDM data from the microphone, already synchronised.
- pcm_data  out  16  signed sample, 2*ones - DECIM, sign-extended.
- pcm_valid  out  1  sample available; held until accepted.
- pcm_ready  in  1  consumer accept.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky; a completed frame was dropped. Cleared on an accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters and the accumulator 0. Reset mid-operation aborts immediately and drops any pending sample.
- Divider:
  - half counter runs only while busy.
  - On entering WARM: counter loads HALF-1 and mic_clk = 0.
  - Each cycle the counter decrements. At 0 it reloads HALF-1 and mic_clk toggles.
  - In IDLE, mic_clk is forced to 0.
- Bit sample event: the cycle in which mic_clk is driven 1->0. mic_data is captured in that cycle.
- Frame: a bit counter counts sample events 0..DECIM-1 and an accumulator counts the ones.
  - On the DECIMth event, the frame completes. The accumulator and bit counter clear in the same cycle, and the current bit counts toward the completed frame.
- States:
  - IDLE: start -> WARM. Frame state is cleared and overrun is cleared.
  - WARM: after WARMUP completed frames (none emitted) -> RUN. stop -> IDLE immediately; no sample is emitted.
  - RUN: each completed frame is offered to the output. stop -> FINISH.
  - FINISH: the current partial frame is completed and offered, then -> IDLE. If stop arrives in the same cycle as a frame completion, that frame is emitted and the next full frame is also captured before IDLE.
- Output register:
  - The cycle after frame completion, pcm_data = 2*ones-DECIM and pcm_valid = 1 (latency 1 clk).
  - pcm_valid stays high and pcm_data stays stable until pcm_valid & pcm_ready.
  - Completion while pcm_valid=1 and pcm_ready=0: the new frame is dropped, the old one is kept, and overrun <= 1.
  - Completion in the same cycle as an accept: the new frame loads and there is no overrun.
  - A pending sample survives the transition to IDLE until it is accepted.
- start and stop in the same cycle while IDLE: start is taken.
- Arithmetic: ones is $clog2(DECIM)+1 bits wide. The result range is -DECIM..+DECIM.

Optional Feature:
- Macro: MIC_STEREO_EN.
- When defined:
  - Adds output port pcm_chan (1 bit; 0 = left, 1 = right).
  - Left bits are sampled on mic_clk 1->0 events and right bits on 0->1 events, using two independent accumulators.
  - The frames complete HALF clk apart and share the same output register, bit counter rules and overrun rule.
  - pcm_chan is reset to 0.
- When undefined: mono only, no pcm_chan port, 0->1 events are unused.

Test Plan:
- Defaults, mic_data=1, start, pcm_ready=1 -> mic_clk period 20 clk. First pcm_valid occurs 1 clk after the 1088th sample event (16 warm-up frames + 1). pcm_data=0x0040, with one sample every 1280 clk.
- mic_data=0 -> pcm_data=0xFFC0. mic_data toggling each sample event -> 0x0000.
- pcm_ready=0 across two completions -> first sample held stable and overrun=1. Next start clears overrun.
- stop at bit 10 of a RUN frame -> one more sample after bits 11..63, then busy=0 and mic_clk=0. A stop issued during WARM -> busy=0 on the next cycle, no pcm_valid.
- reset asserted mid-RUN with pcm_valid=1 -> next cycle pcm_valid=0, busy=0, mic_clk=0, overrun=0.
- MIC_STEREO_EN, left=1 and right=0 -> alternating samples 0x0040 (pcm_chan=0) and 0xFFC0 (pcm_chan=1), 10 clk apart.
